// File: rtl/comparator_pkg.sv
// Shared definitions for the serializer and the bit-serial magnitude comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, MSB-first shift register; also exposes the bit that becomes MSB after the next shift.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb,
    output logic             msb_next
);

    logic [WIDTH-1:0] sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh <= '0;
        end else if (load) begin
            sh <= d;
        end else if (shift) begin
            sh <= {sh[WIDTH-2:0], 1'b0};
        end
    end

    assign msb      = sh[WIDTH-1];
    assign msb_next = sh[WIDTH-2];

endmodule

// File: rtl/operand_serializer.sv
// Captures two parallel operands and streams them MSB-first with clear/valid/last/done
// qualifiers for the downstream bit-serial comparator.
module operand_serializer
    import comparator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             cmp_clr,
    output logic             a_out,
    output logic             b_out,
    output logic             op,
    output logic             last,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             load;
    logic             shift;
    logic             a_msb, a_msb_next, b_msb, b_msb_next;
    logic             busy_d, cmp_clr_d, a_d, b_d, op_d, last_d, done_d;

    piso_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .d        (a_in),
        .msb      (a_msb),
        .msb_next (a_msb_next)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .d        (b_in),
        .msb      (b_msb),
        .msb_next (b_msb_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are computed from the upcoming state so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_cnt   = CNT_W'(WIDTH);
                    next_state = LOAD;
                end
            end
            LOAD: begin
                next_state = SHIFT;
            end
            SHIFT: begin
                shift    = 1'b1;
                next_cnt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    next_cnt   = CNT_W'(WIDTH);
                    next_state = LOAD;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        busy_d    = (next_state == LOAD) || (next_state == SHIFT);
        cmp_clr_d = (next_state == LOAD);
        op_d      = (next_state == SHIFT);
        done_d    = (next_state == DONE);
        last_d    = op_d && (next_cnt == CNT_W'(1));
        a_d       = 1'b0;
        b_d       = 1'b0;
        // Entering SHIFT the register holds the MSB; staying in SHIFT it is about to shift.
        if (state == LOAD) begin
            a_d = a_msb;
            b_d = b_msb;
        end else if ((state == SHIFT) && (next_state == SHIFT)) begin
            a_d = a_msb_next;
            b_d = b_msb_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            busy    <= 1'b0;
            cmp_clr <= 1'b0;
            a_out   <= 1'b0;
            b_out   <= 1'b0;
            op      <= 1'b0;
            last    <= 1'b0;
            done    <= 1'b0;
        end else begin
            cnt     <= next_cnt;
            busy    <= busy_d;
            cmp_clr <= cmp_clr_d;
            a_out   <= a_d;
            b_out   <= b_d;
            op      <= op_d;
            last    <= last_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_operand_serializer.sv
// Self-checking bench for operand_serializer at WIDTH=4 against a per-cycle timeline model.
module tb_operand_serializer;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy, cmp_clr, a_out, b_out, op, last, done;
    logic [6:0]   obs;

    int checks = 0;
    int passes = 0;

    assign obs = {busy, cmp_clr, a_out, b_out, op, last, done};

    operand_serializer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .cmp_clr (cmp_clr),
        .a_out   (a_out),
        .b_out   (b_out),
        .op      (op),
        .last    (last),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {busy,cmp_clr,a_out,b_out,op,last,done} in cycle k after the accepting edge.
    function automatic logic [6:0] model(int k, logic [W-1:0] a, logic [W-1:0] b);
        int idx;
        if (k == 1) return 7'b1100000;
        if (k >= 2 && k <= W + 1) begin
            idx = W + 1 - k;
            return {1'b1, 1'b0, a[idx], b[idx], 1'b1, (k == W + 1), 1'b0};
        end
        if (k == W + 2) return 7'b0000001;
        return 7'b0000000;
    endfunction

    // Call between edges. Leaves time at the negedge of the DONE cycle; hold keeps start high there.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit noise, input bit hold, input string name);
        logic [W-1:0] got_a, got_b;
        logic [6:0]   exp;
        got_a = '0;
        got_b = '0;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= W + 2; k++) begin
            if (k <= W + 1) begin
                start = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
                if (noise) begin
                    a_in = W'($urandom);
                    b_in = W'($urandom);
                end
            end else begin
                start = hold;
            end
            @(negedge clk);
            exp = model(k, a, b);
            checks++;
            if (obs !== exp) $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, k, obs, exp);
            else passes++;
            if (op) begin
                got_a = {got_a[W-2:0], a_out};
                got_b = {got_b[W-2:0], b_out};
            end
            if (k < W + 2) begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if ({got_a, got_b} !== {a, b})
            $display("[TB] FAIL %s stream: got a=%b b=%b expected a=%b b=%b", name, got_a, got_b, a, b);
        else passes++;
    endtask

    task automatic check_idle(input string name);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 7'b0) $display("[TB] FAIL %s: got %b expected 0000000", name, obs);
        else passes++;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        a_in  = 4'b1111;
        b_in  = 4'b1111;
        #2;
        checks++;
        if (obs !== 7'b0) $display("[TB] FAIL reset_init: got %b expected 0000000", obs);
        else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 7'b0) $display("[TB] FAIL reset_held: got %b expected 0000000", obs);
        else passes++;
        start = 1'b0;
        rst   = 1'b1;
        check_idle("idle_after_reset");
    endtask

    task automatic test_directed();
        run_txn(4'b1010, 4'b1010, 1'b0, 1'b0, "equal");
        check_idle("idle_after_equal");
        run_txn(4'b1000, 4'b0111, 1'b0, 1'b0, "a_gt_b_msb");
        check_idle("idle_after_gt");
        run_txn(4'b0110, 4'b0111, 1'b0, 1'b0, "a_lt_b_lsb");
        check_idle("idle_after_lt");
    endtask

    task automatic test_input_change();
        run_txn(4'b1111, 4'b0000, 1'b1, 1'b0, "input_change");
        check_idle("idle_after_input_change");
    endtask

    task automatic test_back_to_back();
        run_txn(4'b1100, 4'b0011, 1'b0, 1'b1, "b2b_first");
        run_txn(4'b0101, 4'b1001, 1'b0, 1'b1, "b2b_second");
        run_txn(4'b1110, 4'b1110, 1'b0, 1'b0, "b2b_third");
        check_idle("idle_after_b2b");
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            run_txn(W'($urandom), W'($urandom), 1'b1, t[0], "random");
        end
        check_idle("idle_after_random");
    endtask

    task automatic test_async_reset();
        a_in  = 4'b1111;
        b_in  = 4'b1011;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b0) $display("[TB] FAIL async_reset_immediate: got %b expected 0000000", obs);
        else passes++;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== 7'b0) $display("[TB] FAIL async_reset_hold cycle %0d: got %b expected 0000000", k, obs);
            else passes++;
        end
        rst = 1'b1;
        run_txn(4'b0011, 4'b1101, 1'b0, 1'b0, "after_reset");
        check_idle("idle_after_reset_txn");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_input_change();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
